// File: rtl/fetch_unit_pkg.sv
// Package fetch_pkg: shared types and constants for the fetch stage.
//   fetch_state_t : FETCH / DRAIN sequencing states
//   word_t        : 32-bit instruction / address word
//   fetch_entry_t : one FIFO entry {pc, instr}
//   branch_target : taken-branch target, branch_pc + 8 + ext_imm (mod 2^32)
package fetch_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic {
    FETCH,
    DRAIN
  } fetch_state_t;

  localparam word_t PC_OFFSET = 32'd8;
  localparam word_t PC_STEP   = 32'd4;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  // Wraps silently modulo 2^32; there is no overflow indication.
  function automatic word_t branch_target(input word_t bpc, input word_t imm);
    return bpc + PC_OFFSET + imm;
  endfunction

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// instr_fifo: DEPTH-entry FIFO of {pc, instr} pairs for the fetch stage.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   push, push_entry : write one entry (ignored when full or flushing)
//   pop            : remove head (ignored when empty or flushing)
//   flush          : discard all entries this cycle; wins over push/pop
//   head           : current head entry (all-zero after reset)
//   full, empty, count : occupancy status
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  fetch_entry_t                 push_entry,
  input  logic                         pop,
  input  logic                         flush,
  output fetch_entry_t                 head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[PW'(i)] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Holds the PC, issues in-order word
// requests over a valid/ready handshake, buffers responses in instr_fifo and
// redirects on taken branches (target = branch_pc + 8 + ext_imm).
// Ports:
//   clk, reset_n                       : clock, asynchronous active-low reset
//   imem_req_valid/ready, imem_addr    : request channel to instruction memory
//   imem_rsp_valid, imem_rsp_data      : in-order responses, no backpressure
//   instr_valid, instr, instr_pc, instr_ready : FIFO head to the decoder
//   branch_taken, branch_pc, ext_imm   : taken-branch redirect
//   perf_redirects, perf_stalls        : only when FETCH_PERF_CNT_EN is defined
// Optional macro: FETCH_PERF_CNT_EN adds redirect and stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter word_t       RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [31:0] ext_imm
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_redirects,
  output logic [31:0] perf_stalls
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  fetch_state_t  state;
  fetch_state_t  state_next;
  word_t         pc;
  word_t         pc_next;
  word_t         pc_eff;
  word_t         req_addr_next;
  logic          req_valid_next;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] out_next;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_next;
  logic [CW:0]   credit;
  logic          accept;
  logic          pending_next;
  logic          issue;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;

  assign accept       = imem_req_valid && imem_req_ready;
  assign pending_next = imem_req_valid && !imem_req_ready;
  assign push         = imem_rsp_valid && (state == FETCH) && !branch_taken;
  assign pop          = instr_valid && instr_ready && !branch_taken;
  assign push_entry   = '{pc: imem_addr_of_rsp(), instr: imem_rsp_data};

  // Responses return strictly in order, so the PC of the word arriving now is
  // the oldest accepted address; it is recovered from the head of the FIFO
  // chain as pc minus the words still owed (outstanding + presented request).
  function automatic word_t imem_addr_of_rsp();
    word_t owed;
    owed = word_t'(outstanding) + (imem_req_valid ? 32'd1 : 32'd0);
    return pc - (owed << 2);
  endfunction

  instr_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (branch_taken),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (occ)
  );

  assign instr_valid = !empty;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

  // pc is the address of the next request still to be presented; it advances
  // when that request is launched, so the held request keeps its own address
  // in imem_addr while a redirect retargets pc underneath it.
  always_comb begin
    out_next       = outstanding + CW'(accept) - CW'(imem_rsp_valid);
    occ_next       = branch_taken ? '0 : occ + CW'(push) - CW'(pop && !empty);
    pc_eff         = branch_taken ? branch_target(branch_pc, ext_imm) : pc;
    state_next     = state;
    case (state)
      FETCH: if (branch_taken && (out_next != '0 || pending_next)) state_next = DRAIN;
      DRAIN: if (!branch_taken && out_next == '0 && !pending_next) state_next = FETCH;
      default: state_next = FETCH;
    endcase
    credit         = {1'b0, out_next} + {1'b0, occ_next};
    issue          = (state_next == FETCH) && !pending_next && !full &&
                     (credit < (CW + 1)'(DEPTH));
    req_valid_next = pending_next || issue;
    req_addr_next  = issue ? pc_eff : imem_addr;
    pc_next        = issue ? pc_eff + PC_STEP : pc_eff;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      outstanding    <= '0;
      imem_req_valid <= 1'b0;
      imem_addr      <= RESET_PC;
    end else begin
      state          <= state_next;
      pc             <= pc_next;
      outstanding    <= out_next;
      imem_req_valid <= req_valid_next;
      imem_addr      <= req_addr_next;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_redirects <= '0;
      perf_stalls    <= '0;
    end else begin
      if (branch_taken) perf_redirects <= perf_redirects + 32'd1;
      if (!instr_valid) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with an in-order memory model,
// a transaction-level reference model checked every cycle, and hand-computed
// expectations for the key scenarios.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_pc = '0;
  logic [31:0] ext_imm = '0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_redirects;
  logic [31:0] perf_stalls;
`endif

  fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .branch_taken  (branch_taken),
    .branch_pc     (branch_pc),
    .ext_imm       (ext_imm)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_redirects(perf_redirects),
    .perf_stalls   (perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory: accepts on handshake, answers one cycle later
  logic [31:0] mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];
  bit          rsp_en = 1'b0;

  always @(posedge clk) begin
    if (reset_n && imem_req_valid && imem_req_ready) begin
      mq.push_back(imem_addr);
      acc_log.push_back(imem_addr);
    end
    #1;
    if (!reset_n) mq.delete();
    if (reset_n && rsp_en && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = data_of(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
    end
  end

  // ---------------- reference model, evaluated between clock edges
  logic [31:0] exp_pc[$];
  logic [31:0] exp_ins[$];
  logic [31:0] infl_addr[$];
  bit          infl_live[$];
  logic [31:0] exp_next;
  logic [31:0] m_pend_addr;
  logic [31:0] m_cur_addr;
  bit          prev_pend;
  bit          pend_live;
  bit          m_cur_live;
  bit          m_drain;
  int          m_credit;

  always @(negedge clk) begin
    if (!reset_n) begin
      exp_pc.delete(); exp_ins.delete(); infl_addr.delete(); infl_live.delete();
      exp_next  = RESET_PC;
      prev_pend = 1'b0;
      pend_live = 1'b1;
    end else begin
      m_drain = prev_pend && !pend_live;
      foreach (infl_live[i]) if (!infl_live[i]) m_drain = 1'b1;
      chk("instr_valid", instr_valid, exp_pc.size() != 0);
      if (instr_valid && exp_pc.size() != 0) begin
        chk("instr", instr, exp_ins[0]);
        chk("instr_pc", instr_pc, exp_pc[0]);
      end
      m_credit = infl_addr.size() + exp_pc.size() + int'(imem_req_valid);
      chk("credit_cap", m_credit <= int'(DEPTH), 1);
      m_cur_live = 1'b1;
      m_cur_addr = imem_addr;
      if (prev_pend) begin
        chk("req_held", imem_req_valid, 1);
        chk("req_addr_stable", imem_addr, m_pend_addr);
        m_cur_live = pend_live;
        m_cur_addr = m_pend_addr;
      end else if (imem_req_valid) begin
        chk("req_in_drain", m_drain, 0);
        chk("req_addr", imem_addr, exp_next);
        m_cur_addr = exp_next;
        exp_next   = exp_next + 32'd4;
      end
      // events that take effect at the coming rising edge
      if (instr_valid && instr_ready && !branch_taken && exp_pc.size() != 0) begin
        void'(exp_pc.pop_front());
        void'(exp_ins.pop_front());
        del_log.push_back(instr_pc);
      end
      if (imem_rsp_valid && infl_addr.size() != 0) begin
        m_pend_addr = infl_addr.pop_front();
        if (infl_live.pop_front() && !branch_taken) begin
          exp_pc.push_back(m_pend_addr);
          exp_ins.push_back(data_of(m_pend_addr));
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        infl_addr.push_back(m_cur_addr);
        infl_live.push_back(m_cur_live);
      end
      prev_pend   = imem_req_valid && !imem_req_ready;
      m_pend_addr = m_cur_addr;
      pend_live   = m_cur_live && !branch_taken;
      if (branch_taken) begin
        exp_pc.delete(); exp_ins.delete();
        foreach (infl_live[i]) infl_live[i] = 1'b0;
        exp_next = branch_pc + 32'd8 + ext_imm;
      end
    end
  end

  // ---------------- directed stimulus
  int base_a;
  int base_d;

  task automatic do_reset();
    @(posedge clk); #3 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic pulse_branch(input logic [31:0] bpc, input logic [31:0] imm);
    branch_taken = 1'b1; branch_pc = bpc; ext_imm = imm;
    @(posedge clk); #1 branch_taken = 1'b0;
  endtask

  task automatic wait_del(input int n, input string name);
    for (int i = 0; i < 60 && del_log.size() < n; i++) @(posedge clk);
    #1 chk(name, del_log.size() >= n, 1);
  endtask

  task automatic wait_acc(input int n, input string name);
    for (int i = 0; i < 60 && acc_log.size() < n; i++) @(posedge clk);
    #1 chk(name, acc_log.size() >= n, 1);
  endtask

  initial begin
    // reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);

    // streaming fetch
    base_a = acc_log.size(); base_d = del_log.size();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rsp_en = 1'b1;
    @(posedge clk); #3 reset_n = 1'b1;
    wait_del(base_d + 3, "stream_wait");
    for (int k = 0; k < 3; k++) begin
      if (acc_log.size() > base_a + k) chk("stream_addr", acc_log[base_a + k], 32'(k * 4));
      if (del_log.size() > base_d + k) chk("stream_pc", del_log[base_d + k], 32'(k * 4));
    end

    // decoder stalled: credit limit holds issue at DEPTH requests
    instr_ready = 1'b0;
    do_reset();
    base_a = acc_log.size();
    repeat (10) @(posedge clk);
    #1;
    chk("stall_req_count", acc_log.size() - base_a, 2);
    chk("stall_req_valid", imem_req_valid, 0);
    chk("stall_instr_valid", instr_valid, 1);
    chk("stall_head_pc", instr_pc, 32'h0);
    instr_ready = 1'b1;
    wait_acc(base_a + 3, "resume_wait");
    if (acc_log.size() > base_a + 2) chk("resume_addr", acc_log[base_a + 2], 32'h8);

    // branch with a request outstanding and another pending
    rsp_en = 1'b0; imem_req_ready = 1'b0;
    do_reset();
    base_a = acc_log.size();
    for (int i = 0; i < 10 && !imem_req_valid; i++) begin @(posedge clk); #1; end
    imem_req_ready = 1'b1;
    @(posedge clk); #1 imem_req_ready = 1'b0;
    pulse_branch(32'h0000_0100, 32'hFFFF_FFF8);
    chk("drain_hold_valid", imem_req_valid, 1);
    chk("drain_hold_addr", imem_addr, 32'h4);
    base_d = del_log.size();
    imem_req_ready = 1'b1; rsp_en = 1'b1;
    wait_del(base_d + 1, "drain_wait");
    if (del_log.size() > base_d) chk("drain_first_pc", del_log[base_d], 32'h100);
    if (acc_log.size() > base_a + 2) chk("drain_new_addr", acc_log[base_a + 2], 32'h100);

    // target wraps modulo 2^32
    repeat (3) @(posedge clk);
    #1 base_d = del_log.size();
    pulse_branch(32'hFFFF_FFF0, 32'h0000_0010);
    wait_del(base_d + 1, "wrap_wait");
    if (del_log.size() > base_d) chk("wrap_target_pc", del_log[base_d], 32'h8);

    // branch coincident with a response and a pop
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (imem_rsp_valid && instr_valid && instr_ready) break;
    end
    chk("coinc_found", imem_rsp_valid && instr_valid, 1);
    base_d = del_log.size();
    branch_taken = 1'b1; branch_pc = 32'h200; ext_imm = 32'h0;
    @(posedge clk); #1 branch_taken = 1'b0;
    chk("coinc_flushed", instr_valid, 0);
    wait_del(base_d + 1, "coinc_wait");
    if (del_log.size() > base_d) chk("coinc_next_pc", del_log[base_d], 32'h208);

    // reset in the middle of DRAIN
    rsp_en = 1'b0;
    repeat (4) @(posedge clk);
    #1 pulse_branch(32'h40, 32'h0);
    @(posedge clk); #3 reset_n = 1'b0;
    #1;
    chk("mid_rst_req_valid", imem_req_valid, 0);
    chk("mid_rst_addr", imem_addr, RESET_PC);
    chk("mid_rst_instr_valid", instr_valid, 0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_instr_pc", instr_pc, 0);
    base_a = acc_log.size();
    repeat (2) @(posedge clk);
    rsp_en = 1'b1;
    @(posedge clk); #3 reset_n = 1'b1;
    wait_acc(base_a + 1, "post_rst_wait");
    if (acc_log.size() > base_a) chk("post_rst_addr", acc_log[base_a], RESET_PC);
    repeat (5) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL global_timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
